aes_round_ctrl: RTL and testbench

Iterative AES-128 encryption engine built around the existing combinational `addRoundKey` block. It accepts a 128-bit plaintext/key pair over a valid/ready handshake and runs the initial key addition plus rounds 1-10, one round per clock. Round keys are expanded on the fly. The ciphertext is held on an output valid/ready port. It sits between the block-level host interface and any downstream cipher-mode logic.

---
 rtl/aes_round_ctrl_if.sv | 23 ++
 rtl/aes_round_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// Host-side handshake bundle for aes_round_ctrl: plaintext/key input port
// and ciphertext output port, each with its own valid/ready pair.
interface aes_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_text;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_text;

  // Host / producer side
  modport master (
    output in_valid, in_text, in_key, out_ready,
    input  in_ready, out_valid, out_text
  );

  // Cipher engine side
  modport slave (
    input  in_valid, in_text, in_key, out_ready,
    output in_ready, out_valid, out_text
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption engine: one round per clock, round keys
// expanded on the fly, ciphertext held until the consumer takes it.
// Optional feature macro: AES_STATS_EN adds the blk_cnt completed-block counter.
// Also holds the small combinational addRoundKey block used for key addition.
module aes_round_ctrl (
  input  logic                   clk,
  input  logic                   rst,
  aes_round_ctrl_if.slave        bus,
  output logic                   busy
`ifdef AES_STATS_EN
  ,
  output logic [15:0]            blk_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t       state_q;
  logic [127:0] st_q;
  logic [127:0] rk_q;
  logic [3:0]   rnd_q;
  logic [7:0]   rcon_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;

  logic [127:0] sb_w;
  logic [127:0] sr_w;
  logic [127:0] mc_w;
  logic [127:0] round_in_d;
  logic [127:0] round_st_d;
  logic [127:0] init_st_d;
  logic [127:0] nk_d;
  logic [31:0]  kw0, kw1, kw2, kw3, ktmp;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as a^254 (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte n of the state sits at bits [127-8n -: 8]; n = row + 4*column.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
    assign sb_w[127-8*gi -: 8] = sbox(st_q[127-8*gi -: 8]);
    // Row r is rotated left by r columns.
    assign sr_w[127-8*gi -: 8] = sb_w[127-8*((gi%4) + 4*(((gi/4) + (gi%4)) % 4)) -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr_w[127-32*gi -: 8];
    assign a1 = sr_w[119-32*gi -: 8];
    assign a2 = sr_w[111-32*gi -: 8];
    assign a3 = sr_w[103-32*gi -: 8];
    assign mc_w[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc_w[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc_w[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc_w[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // The last round skips MixColumns.
  assign round_in_d = (rnd_q == 4'd10) ? sr_w : mc_w;

  // Next round key: SubWord(RotWord(w3)) with rcon on the top byte.
  assign ktmp = {sbox(rk_q[23:16]) ^ rcon_q, sbox(rk_q[15:8]),
                 sbox(rk_q[7:0]), sbox(rk_q[31:24])};
  assign kw0  = rk_q[127:96] ^ ktmp;
  assign kw1  = rk_q[95:64]  ^ kw0;
  assign kw2  = rk_q[63:32]  ^ kw1;
  assign kw3  = rk_q[31:0]   ^ kw2;
  assign nk_d = {kw0, kw1, kw2, kw3};

  addRoundKey u_ark_init (
    .word (bus.in_text),
    .key  (bus.in_key),
    .str  (init_st_d)
  );

  addRoundKey u_ark_round (
    .word (round_in_d),
    .key  (nk_d),
    .str  (round_st_d)
  );

  // Control FSM with registered handshake outputs; rnd holds at 10 in the last round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      st_q        <= '0;
      rk_q        <= '0;
      rnd_q       <= '0;
      rcon_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            st_q       <= init_st_d;
            rk_q       <= bus.in_key;
            rnd_q      <= 4'd1;
            rcon_q     <= 8'h01;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_ROUND;
          end
        end
        S_ROUND: begin
          st_q <= round_st_d;
          rk_q <= nk_d;
          if (rnd_q == 4'd10) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            rnd_q  <= rnd_q + 4'd1;
            rcon_q <= xtime(rcon_q);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_text  = st_q;
  assign busy          = busy_q;

`ifdef AES_STATS_EN
  logic [15:0] blk_cnt_q;

  // Count completed output handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// Combinational round-key addition.
module addRoundKey (
  input  logic [127:0] word,
  input  logic [127:0] key,
  output logic [127:0] str
);
  assign str = word ^ key;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: FIPS-197 vectors, backpressure,
// mid-operation reset, back-to-back throughput and random blocks compared
// against a byte-array AES-128 model. Build with AES_STATS_EN to cover blk_cnt.
module tb_aes_round_ctrl;

  logic clk;
  logic rst;
  logic busy;
`ifdef AES_STATS_EN
  logic [15:0] blk_cnt;
`endif

  aes_round_ctrl_if bus ();

  aes_round_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
`ifdef AES_STATS_EN
    ,
    .blk_cnt (blk_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_INIT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table via generator-3 walk: p runs over 3^k, q over its inverse.
  function automatic void build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
      sbox_t[p] = x;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = mul2(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int i = 0; i < 16; i++) t[i] = s[(i%4) + 4*(((i/4) + (i%4)) % 4)];
      s = t;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) begin
            t[4*c+j] = mul2(s[4*c+j]) ^ mul2(s[4*c+(j+1)%4]) ^ s[4*c+(j+1)%4]
                     ^ s[4*c+(j+2)%4] ^ s[4*c+(j+3)%4];
          end
        end
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one block: accept, junk in_valid during rounds, latency check,
  // optional backpressure with stray in_valid pulses, output handshake.
  task automatic run_block(input string tag, input logic [127:0] txt, input logic [127:0] key,
                           input logic [127:0] exp, input int stall,
                           input bit chk_init, input logic [127:0] init_exp);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq({tag, "_rdy"}, 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    bus.in_text  = txt;
    bus.in_key   = key;
    tick();
    if (chk_init) check_eq({tag, "_init_st"}, dut.st_q, init_exp);
    check_eq({tag, "_busy_rdy"}, 128'({busy, bus.in_ready}), 128'(2'b10));
    n = 1;
    while (!bus.out_valid && n < 40) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_text  = {$urandom, $urandom, $urandom, $urandom};
      bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    check_eq({tag, "_latency"}, 128'(n), 128'(11));
    check_eq({tag, "_ct"}, bus.out_text, exp);
    for (int k = 0; k < stall; k++) begin
      if (k == stall / 2) begin
        bus.in_valid = 1'b1;
        bus.in_text  = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      bus.in_valid = 1'b0;
      check_eq({tag, "_hold_ct"}, bus.out_text, exp);
      check_eq({tag, "_hold_vrb"}, 128'({bus.out_valid, bus.in_ready, busy}), 128'(3'b100));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq({tag, "_post_hs"}, 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
  endtask

  task automatic back_to_back();
    int acc_cyc [2];
    int n_acc;
    int n_out;
    bit acc;
    bit outv;
    logic [127:0] ot;
    logic [127:0] exp_ct [2];
    exp_ct[0] = C1_CT;
    exp_ct[1] = B_CT;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    n_acc = 0;
    n_out = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_text   = C1_PT;
    bus.in_key    = C1_KEY;
    for (int i = 0; i < 60 && n_out < 2; i++) begin
      acc  = bus.in_ready && bus.in_valid;
      outv = bus.out_valid;
      ot   = bus.out_text;
      tick();
      if (acc && n_acc < 2) begin
        acc_cyc[n_acc] = i;
        n_acc++;
        if (n_acc == 1) begin
          bus.in_text = B_PT;
          bus.in_key  = B_KEY;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (outv) begin
        check_eq(n_out == 0 ? "b2b_ct0" : "b2b_ct1", ot, exp_ct[n_out]);
        n_out++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("b2b_outputs", 128'(n_out), 128'(2));
    check_eq("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(12));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] rpt, rkey;
    int n;
    build_sbox();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_text   = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_ctrl", 128'({bus.in_ready, bus.out_valid, busy}), 128'(3'b100));
    check_eq("rst_out_text", bus.out_text, 128'h0);
`ifdef AES_STATS_EN
    check_eq("rst_blk_cnt", 128'(blk_cnt), 128'h0);
`endif
    rst = 1'b0;
    tick();

    back_to_back();
`ifdef AES_STATS_EN
    check_eq("b2b_blk_cnt", 128'(blk_cnt), 128'(2));
`endif
    tick();

    run_block("fips_c1", C1_PT, C1_KEY, C1_CT, 0, 1'b0, 128'h0);
    run_block("fips_b", B_PT, B_KEY, B_CT, 2, 1'b1, B_INIT);
    run_block("bp20", B_PT, B_KEY, B_CT, 20, 1'b0, 128'h0);

    // Reset during round 5: accept, then four more edges.
    bus.in_valid = 1'b1;
    bus.in_text  = C1_PT;
    bus.in_key   = C1_KEY;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check_eq("rst_mid_round", 128'({bus.in_ready, bus.out_valid, busy}), 128'(3'b100));
    tick();
    rst = 1'b0;
    tick();

    // Reset while the result is held: out_valid must drop without a clock edge.
    bus.in_valid = 1'b1;
    bus.in_text  = B_PT;
    bus.in_key   = B_KEY;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq("pre_rst_valid", 128'(bus.out_valid), 128'(1));
    rst = 1'b1;
    #1;
    check_eq("rst_in_done", 128'({bus.in_ready, bus.out_valid}), 128'(2'b10));
    tick();
    rst = 1'b0;
    tick();
    run_block("after_rst_c1", C1_PT, C1_KEY, C1_CT, 1, 1'b0, 128'h0);

    for (int r = 0; r < 6; r++) begin
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_block($sformatf("rand%0d", r), rpt, rkey, model_encrypt(rpt, rkey),
                int'($urandom_range(0, 3)), 1'b0, 128'h0);
    end

`ifdef AES_STATS_EN
    force dut.blk_cnt_q = 16'hffff;
    tick();
    release dut.blk_cnt_q;
    tick();
    check_eq("blk_preload", 128'(blk_cnt), 128'(16'hffff));
    run_block("wrap_blk", C1_PT, C1_KEY, C1_CT, 0, 1'b0, 128'h0);
    check_eq("blk_wrap", 128'(blk_cnt), 128'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
